cnn_maxpool2x2_stream: RTL and testbench

//  Streaming 2x2 / stride-2 max-pool stage downstream of the 3x3 conv+ReLU engine.

---
 rtl/cnn_maxpool2x2_stream.sv | 139 +++++++++++++
 tb/tb_cnn_maxpool2x2_stream.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_maxpool2x2_stream.sv
// cnn_maxpool2x2_stream: streaming 2x2 / stride-2 max-pool for the conv+ReLU output.
// Row-major input over valid/ready, row-major pooled output over valid/ready.
// Even rows leave horizontal pair maxima in a half-row line buffer; odd rows
// combine them with the current pair max to produce each pooled sample.
// Optional feature macro: MAXPOOL_REQUANT_EN (saturate pooled >>> SHIFT to u8).
module cnn_maxpool2x2_stream #(
  parameter int ACC_WIDTH = 32,
  parameter int IN_W      = 26,
  parameter int IN_H      = 26,
  parameter int SHIFT     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACC_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 frame_done
);
  localparam int PW = IN_W / 2;
  localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int RW = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int LW = (PW > 1) ? $clog2(PW) : 1;

  if (IN_W % 2 != 0) begin : g_chk_w
    $error("IN_W must be even");
  end
  if (IN_H % 2 != 0) begin : g_chk_h
    $error("IN_H must be even");
  end
  if (SHIFT < 0) begin : g_chk_s
    $error("SHIFT must be non-negative");
  end

  logic [CW-1:0]                r_col;
  logic [RW-1:0]                r_row;
  logic signed [ACC_WIDTH-1:0]  r_pair;
  logic signed [ACC_WIDTH-1:0]  r_lbuf [PW];
  logic                         r_out_valid;
  logic [ACC_WIDTH-1:0]         r_out_data;
  logic                         r_out_last;
  logic                         r_frame_done;

  logic                         w_acc;
  logic                         w_col_last;
  logic                         w_row_last;
  logic                         w_load;
  logic [LW-1:0]                w_pidx;
  logic signed [ACC_WIDTH-1:0]  w_in;
  logic signed [ACC_WIDTH-1:0]  w_pmax;
  logic signed [ACC_WIDTH-1:0]  w_lb;
  logic signed [ACC_WIDTH-1:0]  w_pool;
  logic [ACC_WIDTH-1:0]         w_res;

  assign in_ready   = !r_out_valid || out_ready;
  // clear wins over a same-cycle input handshake
  assign w_acc      = in_valid && in_ready && !clear;
  assign w_col_last = (r_col == CW'(IN_W - 1));
  assign w_row_last = (r_row == RW'(IN_H - 1));
  assign w_pidx     = LW'(r_col >> 1);
  assign w_in       = in_data;
  assign w_pmax     = (w_in > r_pair) ? w_in : r_pair;
  assign w_lb       = r_lbuf[w_pidx];
  assign w_pool     = (w_pmax > w_lb) ? w_pmax : w_lb;
  // 4th sample of a 2x2 window: odd column of an odd row
  assign w_load     = w_acc && r_col[0] && r_row[0];

`ifdef MAXPOOL_REQUANT_EN
  localparam logic signed [ACC_WIDTH-1:0] U8MAX = 255;
  logic signed [ACC_WIDTH-1:0] w_shr;
  assign w_shr = w_pool >>> SHIFT;
  // saturate the shifted pooled value into 0..255, zero-extended
  always_comb begin
    w_res = '0;
    if (w_shr[ACC_WIDTH-1])  w_res = '0;
    else if (w_shr > U8MAX)  w_res = U8MAX;
    else                     w_res = {{(ACC_WIDTH-8){1'b0}}, w_shr[7:0]};
  end
`else
  assign w_res = w_pool;
`endif

  // position counters and the even-column pair register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= '0;
      r_row  <= '0;
      r_pair <= '0;
    end else if (clear) begin
      r_col  <= '0;
      r_row  <= '0;
      r_pair <= '0;
    end else if (w_acc) begin
      if (!r_col[0]) r_pair <= w_in;
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // half-row line buffer of even-row pair maxima; contents need no reset
  always_ff @(posedge clk) begin
    if (w_acc && r_col[0] && !r_row[0]) r_lbuf[w_pidx] <= w_pmax;
  end

  // single-entry output register; load and drain may coincide without a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (clear) begin
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= r_out_valid && out_ready && r_out_last;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_res;
        r_out_last  <= w_row_last && w_col_last;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_cnn_maxpool2x2_stream.sv
// Directed bench for cnn_maxpool2x2_stream: a table of single 2x2-window frames,
// then ramp, backpressure, clear and async-reset sequences.
module tb_cnn_maxpool2x2_stream;
  localparam int AW = 32;
  localparam int W  = 26;
  localparam int H  = 26;
  localparam int NOUT = (W / 2) * (H / 2);
`ifdef MAXPOOL_REQUANT_EN
  localparam int SH = 2;
  localparam bit RQ = 1'b1;
`else
  localparam int SH = 0;
  localparam bit RQ = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic          frame_done;

  cnn_maxpool2x2_stream #(.ACC_WIDTH(AW), .IN_W(W), .IN_H(H), .SHIFT(SH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  int fd_cnt;
  logic signed [AW-1:0] got[$];

  // consumer side: inputs only change just after posedge, so negedge sees the upcoming edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) got.push_back(out_data);
      if (frame_done) fd_cnt++;
    end
  end

  task automatic check(input string name, input logic signed [AW-1:0] act,
                       input logic signed [AW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // requant model for ramp-derived values (identity in the default build)
  function automatic logic signed [AW-1:0] eq(input logic signed [AW-1:0] p);
    logic signed [AW-1:0] s;
    if (!RQ) return p;
    s = p >>> SH;
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  task automatic reset_q();
    got.delete();
    fd_cnt = 0;
  endtask

  task automatic drive_sample(input logic signed [AW-1:0] d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL in_ready_timeout: in_ready stuck at 0 for %0d cycles, required 1", t);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_ramp(input int n);
    for (int i = 0; i < n; i++) drive_sample(AW'((i / W) * W + (i % W)));
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_ramp(input string name);
    int errs;
    int r;
    int c;
    errs = 0;
    check({name, "_count"}, got.size(), NOUT);
    for (int k = 0; k < got.size() && k < NOUT; k++) begin
      r = k / (W / 2);
      c = k % (W / 2);
      if (got[k] !== eq(AW'((2 * r + 1) * W + 2 * c + 1))) errs++;
    end
    check({name, "_values_bad"}, errs, 0);
    check({name, "_first"}, got[0], eq(27));
    check({name, "_last"}, got[NOUT-1], eq(675));
    check({name, "_frame_done"}, fd_cnt, 1);
  endtask

  typedef struct {
    logic signed [AW-1:0] a, b, c, d;   // window (0,0),(0,1),(1,0),(1,1)
    logic signed [AW-1:0] e;            // full-width pooled max
    logic signed [AW-1:0] e_rq;         // requant build, SHIFT=2
  } vec_t;
  vec_t vt[12];

  initial begin : wdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic signed [AW-1:0] v;
    logic signed [AW-1:0] x;
    int errs;
    n_tests = 0;
    n_fail  = 0;
    fd_cnt  = 0;

    vt[0]  = '{-5, -3, -9, -7, -3, 0};
    vt[1]  = '{1, 2, 3, 4, 4, 1};
    vt[2]  = '{4, 3, 2, 1, 4, 1};
    vt[3]  = '{-1, -2, -3, -4, -1, 0};
    vt[4]  = '{32'sh80000000, -1, 32'sh80000000, 32'sh80000000, -1, 0};
    vt[5]  = '{32'sh7fffffff, 0, 0, 0, 32'sh7fffffff, 255};
    vt[6]  = '{7, 100, -100, 99, 100, 25};
    vt[7]  = '{1023, 0, 0, 0, 1023, 255};
    vt[8]  = '{0, 1024, 0, 0, 1024, 255};
    vt[9]  = '{0, 0, 8, 0, 8, 2};
    vt[10] = '{-4, -4, -4, -4, -4, 0};
    vt[11] = '{1019, 1020, 3, 2, 1020, 255};

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // table: one non-zero window at (0,0), all other samples 0
    for (int i = 0; i < 12; i++) begin
      reset_q();
      for (int r = 0; r < H; r++) begin
        for (int c = 0; c < W; c++) begin
          v = 0;
          if (r == 0 && c == 0) v = vt[i].a;
          if (r == 0 && c == 1) v = vt[i].b;
          if (r == 1 && c == 0) v = vt[i].c;
          if (r == 1 && c == 1) v = vt[i].d;
          drive_sample(v);
        end
      end
      drain();
      x = RQ ? vt[i].e_rq : vt[i].e;
      check($sformatf("vec%0d_count", i), got.size(), NOUT);
      check($sformatf("vec%0d_pooled", i), got[0], x);
      errs = 0;
      for (int k = 1; k < got.size(); k++) if (got[k] !== 0) errs++;
      check($sformatf("vec%0d_rest_nonzero", i), errs, 0);
      check($sformatf("vec%0d_frame_done", i), fd_cnt, 1);
    end

    // ramp frame, consumer always ready
    reset_q();
    send_ramp(W * H);
    drain();
    check_ramp("ramp");

    // backpressure: hold out_ready low for 5 cycles after the first out_valid
    reset_q();
    out_ready = 1'b0;
    fork
      send_ramp(W * H);
      begin : stall
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 2000) begin
          @(negedge clk);
          t++;
        end
        check("bp_valid_seen", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
          check("bp_hold_data", out_data, eq(27));
          check("bp_in_ready_low", in_ready, 0);
          if (k < 4) @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check_ramp("bp");

    // clear with a pending output and a competing input handshake
    reset_q();
    send_ramp(100);
    check("clr_pending", out_valid, 1);
    out_ready = 1'b0;
    clear     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 999;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_out_valid", out_valid, 0);
    check("clr_in_ready", in_ready, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    reset_q();
    send_ramp(W * H);
    drain();
    check_ramp("clr");

    // asynchronous reset mid-frame
    reset_q();
    send_ramp(60);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    reset_q();
    send_ramp(W * H);
    drain();
    check_ramp("arst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
